// File: rtl/seq_pair_loader_if.sv
// Handshake and accelerator-side bundle for seq_pair_loader.
// slave  : the loader's view (consumes bytes, drives R/Q/start/status).
// master : the environment's view (feeds bytes, drives acc_ready).
// Optional macro SEQ_PAIR_LOADER_TIMEOUT_EN adds the timeout_err signal.
interface seq_pair_loader_if #(
  parameter int L = 8
);
  logic             in_valid;
  logic             in_ready;
  logic [7:0]       in_data;
  logic             in_last;
  logic [3*L-1:0]   R;
  logic [3*L-1:0]   Q;
  logic             start;
  logic             acc_ready;
  logic             done;
  logic             busy;
  logic             err_len;
  logic [7:0]       pair_count;
`ifdef SEQ_PAIR_LOADER_TIMEOUT_EN
  logic             timeout_err;
`endif

  modport slave (
    input  in_valid, in_data, in_last, acc_ready,
    output in_ready, R, Q, start, done, busy, err_len, pair_count
`ifdef SEQ_PAIR_LOADER_TIMEOUT_EN
    , output timeout_err
`endif
  );

  modport master (
    output in_valid, in_data, in_last, acc_ready,
    input  in_ready, R, Q, start, done, busy, err_len, pair_count
`ifdef SEQ_PAIR_LOADER_TIMEOUT_EN
    , input timeout_err
`endif
  );
endinterface

// File: rtl/seq_pair_loader.sv
// seq_pair_loader: encodes an ASCII nucleotide stream into 3-bit symbols,
// packs one reference and one query window of L symbols (first base at the
// MSBs), launches the accelerator with a one-cycle start pulse and waits for
// a rising edge of acc_ready before accepting the next pair.
// Optional macro SEQ_PAIR_LOADER_TIMEOUT_EN enables a WAIT-state watchdog of
// TIMEOUT cycles that raises a sticky timeout_err and abandons the pair.
module seq_pair_loader #(
  parameter int L       = 8,
  parameter int TIMEOUT = 255
) (
  input  logic clk,
  input  logic reset,
  seq_pair_loader_if.slave bus
);

  localparam int W  = 3 * L;
  localparam int CW = $clog2(L + 1);
  localparam logic [CW-1:0] L_CNT = CW'(L);

  // Reject nonsensical configurations at elaboration time.
  if (L < 1 || TIMEOUT < 1) begin : g_param_check
    $error("seq_pair_loader: L and TIMEOUT must be at least 1");
  end

  typedef enum logic [1:0] {
    ST_LOAD_R = 2'd0,
    ST_LOAD_Q = 2'd1,
    ST_START  = 2'd2,
    ST_WAIT   = 2'd3
  } state_t;

  state_t          state_q;
  logic [CW-1:0]   cnt_q;
  logic [W-1:0]    r_buf_q, r_buf_d;
  logic [W-1:0]    q_buf_q, q_buf_d;
  logic [W-1:0]    r_q, q_q;
  logic            start_q;
  logic            done_q;
  logic            err_len_q;
  logic [7:0]      pair_count_q;
  logic            acc_prev_q;

  logic            in_ready;
  logic            beat;
  logic            has_room;
  logic            wr_r, wr_q;
  logic            acc_rise;
  logic [2:0]      sym;

  // Map an ASCII byte to its 3-bit symbol; 3'b000 stays reserved for padding.
  function automatic logic [2:0] encode_base(input logic [7:0] b);
    case (b)
      8'h41, 8'h61: encode_base = 3'b001;  // A / a
      8'h43, 8'h63: encode_base = 3'b010;  // C / c
      8'h47, 8'h67: encode_base = 3'b011;  // G / g
      8'h54, 8'h74: encode_base = 3'b100;  // T / t
      default:      encode_base = 3'b101;  // N
    endcase
  endfunction

  assign in_ready = (state_q == ST_LOAD_R) || (state_q == ST_LOAD_Q);
  assign beat     = bus.in_valid && in_ready;
  assign has_room = (cnt_q < L_CNT);
  assign wr_r     = beat && has_room && (state_q == ST_LOAD_R);
  assign wr_q     = beat && has_room && (state_q == ST_LOAD_Q);
  assign sym      = encode_base(bus.in_data);
  assign acc_rise = bus.acc_ready && !acc_prev_q;

  // Next buffer contents: the slot selected by cnt takes the new symbol.
  for (genvar gi = 0; gi < L; gi++) begin : g_slot
    assign r_buf_d[W-1-3*gi -: 3] = (wr_r && cnt_q == CW'(gi)) ? sym : r_buf_q[W-1-3*gi -: 3];
    assign q_buf_d[W-1-3*gi -: 3] = (wr_q && cnt_q == CW'(gi)) ? sym : q_buf_q[W-1-3*gi -: 3];
  end

`ifdef SEQ_PAIR_LOADER_TIMEOUT_EN
  localparam int WDW = $clog2(TIMEOUT + 1);
  localparam logic [WDW-1:0] WD_LIMIT = WDW'(TIMEOUT - 1);
  logic [WDW-1:0] wd_q;
  logic           timeout_err_q;
  assign bus.timeout_err = timeout_err_q;
`endif

  // Control FSM: loads R then Q, launches, then waits for the accelerator.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= ST_LOAD_R;
      cnt_q        <= '0;
      r_buf_q      <= '0;
      q_buf_q      <= '0;
      r_q          <= '0;
      q_q          <= '0;
      start_q      <= 1'b0;
      done_q       <= 1'b0;
      err_len_q    <= 1'b0;
      pair_count_q <= '0;
      acc_prev_q   <= 1'b0;
`ifdef SEQ_PAIR_LOADER_TIMEOUT_EN
      wd_q          <= '0;
      timeout_err_q <= 1'b0;
`endif
    end else begin
      start_q <= 1'b0;
      done_q  <= 1'b0;
      case (state_q)
        ST_LOAD_R: begin
          if (beat) begin
            // A fresh reference sequence clears the previous length error.
            if (cnt_q == '0) err_len_q <= 1'b0;
            if (has_room) begin
              r_buf_q <= r_buf_d;
              cnt_q   <= cnt_q + 1'b1;
            end else begin
              err_len_q <= 1'b1;
            end
            if (bus.in_last) begin
              cnt_q   <= '0;
              state_q <= ST_LOAD_Q;
            end
          end
        end
        ST_LOAD_Q: begin
          if (beat) begin
            if (has_room) begin
              q_buf_q <= q_buf_d;
              cnt_q   <= cnt_q + 1'b1;
            end else begin
              err_len_q <= 1'b1;
            end
            if (bus.in_last) begin
              // Publish R/Q together with start so both are valid in START.
              cnt_q   <= '0;
              r_q     <= r_buf_q;
              q_q     <= q_buf_d;
              start_q <= 1'b1;
              state_q <= ST_START;
            end
          end
        end
        ST_START: begin
          // Treat acc_ready as already high so a stale level is not an edge.
          acc_prev_q <= 1'b1;
`ifdef SEQ_PAIR_LOADER_TIMEOUT_EN
          wd_q <= '0;
`endif
          state_q <= ST_WAIT;
        end
        ST_WAIT: begin
          acc_prev_q <= bus.acc_ready;
          if (acc_rise) begin
            done_q       <= 1'b1;
            pair_count_q <= pair_count_q + 8'd1;
            r_buf_q      <= '0;
            q_buf_q      <= '0;
            cnt_q        <= '0;
            state_q      <= ST_LOAD_R;
`ifdef SEQ_PAIR_LOADER_TIMEOUT_EN
            timeout_err_q <= 1'b0;
          end else if (wd_q == WD_LIMIT) begin
            timeout_err_q <= 1'b1;
            r_buf_q       <= '0;
            q_buf_q       <= '0;
            cnt_q         <= '0;
            state_q       <= ST_LOAD_R;
          end else begin
            wd_q <= wd_q + 1'b1;
`endif
          end
        end
        default: state_q <= ST_LOAD_R;
      endcase
    end
  end

  assign bus.in_ready   = in_ready;
  assign bus.busy       = (state_q == ST_START) || (state_q == ST_WAIT);
  assign bus.R          = r_q;
  assign bus.Q          = q_q;
  assign bus.start      = start_q;
  assign bus.done       = done_q;
  assign bus.err_len    = err_len_q;
  assign bus.pair_count = pair_count_q;

endmodule

// File: tb/tb_seq_pair_loader.sv
// Directed testbench for seq_pair_loader (L = 8, TIMEOUT = 20).
module tb_seq_pair_loader;

  logic clk;
  logic reset;
  int   vectors;
  int   miscompares;

  seq_pair_loader_if #(.L(8)) bus();

  seq_pair_loader #(.L(8), .TIMEOUT(20)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation still running, required finish");
    $fatal(1, "global timeout");
  end

  // Present one byte and hold it until the loader accepts it.
  task automatic send_byte(input logic [7:0] b, input logic last);
    int waited;
    waited = 0;
    while (!bus.in_ready && waited < 50) begin
      @(posedge clk); #1;
      waited++;
    end
    vectors++;
    if (bus.in_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL in_ready_wait: in_ready=%b required 1", bus.in_ready);
    end
    bus.in_valid = 1'b1;
    bus.in_data  = b;
    bus.in_last  = last;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    bus.in_last  = 1'b0;
  endtask

  task automatic send_seq(input string s);
    for (int i = 0; i < s.len(); i++)
      send_byte(s[i], (i == s.len() - 1));
  endtask

  // From the START cycle: one START edge, one low WAIT sample, then a rising edge.
  task automatic pulse_acc();
    @(posedge clk); #1;
    @(posedge clk); #1;
    bus.acc_ready = 1'b1;
    @(posedge clk); #1;
    bus.acc_ready = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    #3;
    vectors++;
    if (bus.in_ready !== 1'b1) begin miscompares++; $display("FAIL reset_in_ready: got %b required 1", bus.in_ready); end
    vectors++;
    if ({bus.start, bus.done, bus.busy, bus.err_len} !== 4'b0000) begin
      miscompares++; $display("FAIL reset_flags: start/done/busy/err=%b required 0000", {bus.start, bus.done, bus.busy, bus.err_len});
    end
    vectors++;
    if (bus.R !== 24'o0 || bus.Q !== 24'o0 || bus.pair_count !== 8'd0) begin
      miscompares++; $display("FAIL reset_data: R=%o Q=%o cnt=%0d required 0/0/0", bus.R, bus.Q, bus.pair_count);
    end
    @(posedge clk); #1;
    reset = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_full_pair();
    send_seq("ACGTACGT");
    send_seq("TTGCANGA");
    vectors++;
    if (bus.start !== 1'b1) begin miscompares++; $display("FAIL full_start: got %b required 1", bus.start); end
    vectors++;
    if (bus.R !== 24'o12341234) begin miscompares++; $display("FAIL full_R: got %o required 12341234", bus.R); end
    vectors++;
    if (bus.Q !== 24'o44321531) begin miscompares++; $display("FAIL full_Q: got %o required 44321531", bus.Q); end
    vectors++;
    if (bus.busy !== 1'b1 || bus.in_ready !== 1'b0) begin
      miscompares++; $display("FAIL full_busy: busy=%b in_ready=%b required 1/0", bus.busy, bus.in_ready);
    end
    @(posedge clk); #1;
    vectors++;
    if (bus.start !== 1'b0 || bus.busy !== 1'b1) begin
      miscompares++; $display("FAIL full_start_once: start=%b busy=%b required 0/1", bus.start, bus.busy);
    end
    @(posedge clk); #1;
    bus.acc_ready = 1'b1;
    @(posedge clk); #1;
    bus.acc_ready = 1'b0;
    vectors++;
    if (bus.done !== 1'b1 || bus.pair_count !== 8'd1) begin
      miscompares++; $display("FAIL full_done: done=%b cnt=%0d required 1/1", bus.done, bus.pair_count);
    end
    vectors++;
    if (bus.R !== 24'o12341234) begin miscompares++; $display("FAIL full_R_hold: got %o required 12341234", bus.R); end
    @(posedge clk); #1;
    vectors++;
    if (bus.done !== 1'b0 || bus.in_ready !== 1'b1) begin
      miscompares++; $display("FAIL full_done_once: done=%b in_ready=%b required 0/1", bus.done, bus.in_ready);
    end
  endtask

  task automatic test_short_pair();
    send_seq("AC");
    send_seq("g");
    vectors++;
    if (bus.R !== 24'o12000000 || bus.Q !== 24'o30000000) begin
      miscompares++; $display("FAIL short_RQ: R=%o Q=%o required 12000000/30000000", bus.R, bus.Q);
    end
    vectors++;
    if (bus.err_len !== 1'b0) begin miscompares++; $display("FAIL short_err: got %b required 0", bus.err_len); end
    pulse_acc();
    vectors++;
    if (bus.pair_count !== 8'd2) begin miscompares++; $display("FAIL short_count: got %0d required 2", bus.pair_count); end
    @(posedge clk); #1;
  endtask

  task automatic test_overlength();
    send_seq("ACGTACGTCA");
    send_seq("A");
    vectors++;
    if (bus.R !== 24'o12341234) begin miscompares++; $display("FAIL over_R: got %o required 12341234", bus.R); end
    vectors++;
    if (bus.Q !== 24'o10000000) begin miscompares++; $display("FAIL over_Q: got %o required 10000000", bus.Q); end
    vectors++;
    if (bus.err_len !== 1'b1) begin miscompares++; $display("FAIL over_err: got %b required 1", bus.err_len); end
    pulse_acc();
    vectors++;
    if (bus.err_len !== 1'b1 || bus.pair_count !== 8'd3) begin
      miscompares++; $display("FAIL over_err_sticky: err=%b cnt=%0d required 1/3", bus.err_len, bus.pair_count);
    end
    @(posedge clk); #1;
    send_byte("G", 1'b0);
    vectors++;
    if (bus.err_len !== 1'b0) begin miscompares++; $display("FAIL over_err_clear: got %b required 0", bus.err_len); end
    send_byte("T", 1'b1);
    send_seq("C");
    vectors++;
    if (bus.R !== 24'o34000000 || bus.Q !== 24'o20000000) begin
      miscompares++; $display("FAIL over_next_RQ: R=%o Q=%o required 34000000/20000000", bus.R, bus.Q);
    end
    pulse_acc();
    vectors++;
    if (bus.pair_count !== 8'd4) begin miscompares++; $display("FAIL over_next_count: got %0d required 4", bus.pair_count); end
    @(posedge clk); #1;
  endtask

  task automatic test_stale_ready();
    send_seq("A");
    bus.acc_ready = 1'b1;
    send_seq("C");
    for (int i = 0; i < 5; i++) begin
      bus.in_valid = 1'b1;
      bus.in_data  = "G";
      bus.in_last  = 1'b1;
      @(posedge clk); #1;
      vectors++;
      if (bus.done !== 1'b0 || bus.in_ready !== 1'b0 || bus.busy !== 1'b1) begin
        miscompares++; $display("FAIL stale_hold[%0d]: done=%b in_ready=%b busy=%b required 0/0/1", i, bus.done, bus.in_ready, bus.busy);
      end
    end
    vectors++;
    if (bus.R !== 24'o10000000 || bus.Q !== 24'o20000000) begin
      miscompares++; $display("FAIL stale_RQ: R=%o Q=%o required 10000000/20000000", bus.R, bus.Q);
    end
    bus.in_valid = 1'b0;
    bus.in_last  = 1'b0;
    bus.acc_ready = 1'b0;
    @(posedge clk); #1;
    vectors++;
    if (bus.done !== 1'b0) begin miscompares++; $display("FAIL stale_low: done=%b required 0", bus.done); end
    bus.acc_ready = 1'b1;
    @(posedge clk); #1;
    bus.acc_ready = 1'b0;
    vectors++;
    if (bus.done !== 1'b1 || bus.pair_count !== 8'd5) begin
      miscompares++; $display("FAIL stale_done: done=%b cnt=%0d required 1/5", bus.done, bus.pair_count);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_reset_mid();
    send_seq("ACGT");
    send_byte("G", 1'b0);
    send_byte("G", 1'b0);
    send_byte("G", 1'b0);
    reset = 1'b1;
    #1;
    vectors++;
    if (bus.in_ready !== 1'b1 || bus.busy !== 1'b0 || bus.start !== 1'b0) begin
      miscompares++; $display("FAIL mid_reset_ctl: in_ready=%b busy=%b start=%b required 1/0/0", bus.in_ready, bus.busy, bus.start);
    end
    vectors++;
    if (bus.R !== 24'o0 || bus.Q !== 24'o0 || bus.pair_count !== 8'd0) begin
      miscompares++; $display("FAIL mid_reset_data: R=%o Q=%o cnt=%0d required 0/0/0", bus.R, bus.Q, bus.pair_count);
    end
    #1;
    reset = 1'b0;
    @(posedge clk); #1;
    send_seq("CA");
    send_seq("TG");
    vectors++;
    if (bus.R !== 24'o21000000 || bus.Q !== 24'o43000000) begin
      miscompares++; $display("FAIL mid_fresh_RQ: R=%o Q=%o required 21000000/43000000", bus.R, bus.Q);
    end
    pulse_acc();
    vectors++;
    if (bus.done !== 1'b1 || bus.pair_count !== 8'd1) begin
      miscompares++; $display("FAIL mid_fresh_done: done=%b cnt=%0d required 1/1", bus.done, bus.pair_count);
    end
    @(posedge clk); #1;
  endtask

`ifdef SEQ_PAIR_LOADER_TIMEOUT_EN
  task automatic test_timeout();
    send_seq("A");
    send_seq("T");
    // START cycle now; the START edge enters WAIT, then 20 WAIT cycles elapse.
    for (int i = 0; i < 20; i++) @(posedge clk);
    #1;
    vectors++;
    if (bus.timeout_err !== 1'b0 || bus.busy !== 1'b1) begin
      miscompares++; $display("FAIL to_early: timeout_err=%b busy=%b required 0/1", bus.timeout_err, bus.busy);
    end
    @(posedge clk); #1;
    vectors++;
    if (bus.timeout_err !== 1'b1 || bus.in_ready !== 1'b1 || bus.done !== 1'b0) begin
      miscompares++; $display("FAIL to_fire: timeout_err=%b in_ready=%b done=%b required 1/1/0", bus.timeout_err, bus.in_ready, bus.done);
    end
    vectors++;
    if (bus.pair_count !== 8'd1) begin miscompares++; $display("FAIL to_count: got %0d required 1", bus.pair_count); end
    send_seq("G");
    send_seq("G");
    pulse_acc();
    vectors++;
    if (bus.timeout_err !== 1'b0 || bus.pair_count !== 8'd2) begin
      miscompares++; $display("FAIL to_clear: timeout_err=%b cnt=%0d required 0/2", bus.timeout_err, bus.pair_count);
    end
    @(posedge clk); #1;
  endtask
`endif

  initial begin
    vectors       = 0;
    miscompares   = 0;
    reset         = 1'b1;
    bus.in_valid  = 1'b0;
    bus.in_data   = 8'h00;
    bus.in_last   = 1'b0;
    bus.acc_ready = 1'b0;
    test_reset();
    test_full_pair();
    test_short_pair();
    test_overlength();
    test_stale_ready();
    test_reset_mid();
`ifdef SEQ_PAIR_LOADER_TIMEOUT_EN
    test_timeout();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/seq_pair_loader.md
Name: seq_pair_loader

Overview:
Upstream feeder for the banded Smith-Waterman accelerator. It accepts an ASCII nucleotide byte stream through a valid/ready handshake and encodes each base to the 3-bit symbol code. It packs one reference window (R) and one query window (Q) of L symbols each, then pulses start to the accelerator. It holds R/Q stable until the accelerator's ready rises, then counts the completed pair and accepts the next pair.

Parameters:
L, 8, symbols per sequence window; R/Q width is 3*L.
TIMEOUT, 255, watchdog limit in cycles; used only with the optional feature.

Ports:
clk  input  1  system clock, rising-edge.
reset  input  1  asynchronous, active-high reset.
in_valid  input  1  in_data holds a base.
in_ready  output  1  loader can accept a byte this cycle.
in_data  input  8  ASCII base character.
in_last  input  1  final byte of the current sequence (R, then Q).
R  output  3*L  packed reference window to the accelerator.
Q  output  3*L  packed query window to the accelerator.
start  output  1  one-cycle launch pulse to the accelerator.
acc_ready  input  1  accelerator ready/finished flag.
done  output  1  one-cycle pulse when a pair completes.
busy  output  1  high in START and WAIT.
err_len  output  1  sticky flag: a sequence exceeded L bases.
pair_count  output  8  number of completed pairs, wraps 255->0.

Behaviour:
- Encoding:
  - 'A'/'a' -> 3'b001, 'C'/'c' -> 3'b010, 'G'/'g' -> 3'b011, 'T'/'t' -> 3'b100.
  - Any other byte -> 3'b101 (N).
  - 3'b000 is reserved for padding.
- Packing: symbol i (0-based arrival order) is placed at bits [3L-1-3i : 3L-3-3i], so the first base sits at the MSBs. Unfilled positions remain 3'b000.
- Transfer: a beat occurs when in_valid && in_ready. in_ready = 1 only in LOAD_R and LOAD_Q. Inputs on non-ready cycles are ignored.
- States:
  - LOAD_R (reset state):
    - Beats fill r_buf via symbol counter cnt (0..L).
    - A beat with cnt == L is dropped and sets err_len.
    - A beat with in_last -> LOAD_Q, cnt <= 0.
  - LOAD_Q: same rules into q_buf. A beat with in_last -> START.
  - START:
    - Exactly one cycle with start = 1.
    - R <= r_buf and Q <= q_buf on entry, so the new values are visible during the start cycle.
    - Next state: WAIT.
  - WAIT:
    - Waits for a rising edge of acc_ready. The previous-sample register is forced to 1 on WAIT entry, so a stale high level from the prior run is ignored.
    - On the edge: done = 1 for one cycle, pair_count += 1, clear r_buf/q_buf/cnt -> LOAD_R.
- R/Q change only on the START cycle and are otherwise held, including throughout WAIT.
- err_len is cleared on the first accepted beat of a new R sequence. A beat with in_last that is also over-length still ends the sequence.
- A single-byte sequence is legal: one symbol, remainder padded.
- Reset values:
  - State LOAD_R, in_ready 1, all other outputs 0.
  - R, Q, buffers and counters all 0.
- Asynchronous reset mid-operation aborts immediately. start is never left high; any partial pair is discarded.

Optional Feature:
SEQ_PAIR_LOADER_TIMEOUT_EN:
- Defined: a watchdog counter runs in WAIT. If TIMEOUT cycles pass without an acc_ready rising edge, the loader:
  - asserts output timeout_err (sticky, 1 bit; cleared by reset or the next successful done);
  - clears buffers and returns to LOAD_R;
  - does not pulse done and does not increment pair_count.
- Undefined: no counter and no timeout_err port; WAIT waits indefinitely.

Test Plan:
- Send "ACGTACGT" (last on 8th) then "TTGCANGA" -> R = 24'o12341234, Q = 24'o44321531, start high one cycle, busy = 1. Then pulse acc_ready -> done one cycle, pair_count = 1.
- Send R = "AC" (last on 2nd) and Q = "G" -> R = 24'o12000000, Q = 24'o30000000; err_len = 0.
- Send a 10-byte R -> bytes 9 and 10 dropped, R holds the first 8 symbols, err_len = 1. The next pair's first R beat clears err_len.
- Hold acc_ready = 1 continuously across START/WAIT -> no done until acc_ready falls and rises again. in_ready = 0 and in_valid bytes are ignored throughout.
- Assert reset in LOAD_Q after 3 Q bytes -> all outputs 0 and in_ready = 1 immediately; a fresh pair then loads correctly.
- With SEQ_PAIR_LOADER_TIMEOUT_EN and TIMEOUT = 20, never raise acc_ready -> timeout_err = 1 after 20 WAIT cycles, state LOAD_R, pair_count unchanged.
